rtc_time_snapshot: RTL and testbench

- Sits between time_counter (1 Hz domain) and the APB register file (APB clock domain).
- Synchronises the 1 Hz tick into the APB clock.
- Waits for the live time fields to settle, then double-samples them until two samples agree.
- Presents one coherent time snapshot over a valid/ready handshake; the register-file glue consumes it as the cur_* field values.

---
 rtl/rtc_snap_pkg.sv | 26 ++
 rtl/rtc_time_snapshot_if.sv | 22 ++
 rtl/rtc_tick_sync.sv | 27 ++
 rtl/rtc_time_snapshot.sv | 162 ++++++++++++++++
 tb/tb_rtc_time_snapshot.sv | 381 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rtc_snap_pkg.sv
// rtc_snap_pkg: shared types for the RTC time snapshot block.
// Packed time layout, FSM state encoding and time width.
package rtc_snap_pkg;

  localparam int RTC_TIME_W = 44;

  typedef struct packed {
    logic [11:0] year;
    logic [3:0]  month;
    logic [4:0]  dom;
    logic [2:0]  dow;
    logic [1:0]  mode;
    logic [5:0]  hour;
    logic [5:0]  min;
    logic [5:0]  sec;
  } rtc_time_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_VERIFY,
    S_PRESENT
  } snap_state_e;

endpackage

// File: rtl/rtc_time_snapshot_if.sv
// rtc_time_snapshot_if: snapshot valid/ready handshake bundle.
// master = snapshot producer, slave = register-file consumer.
interface rtc_time_snapshot_if;
  import rtc_snap_pkg::*;

  rtc_time_t snap_time;
  logic      snap_valid;
  logic      snap_ready;

  modport master (
    output snap_time,
    output snap_valid,
    input  snap_ready
  );

  modport slave (
    input  snap_time,
    input  snap_valid,
    output snap_ready
  );

endinterface

// File: rtl/rtc_tick_sync.sv
// rtc_tick_sync: synchroniser chain plus registered rising-edge detector
// for the asynchronous 1 Hz tick.
module rtc_tick_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic tick_async_i,
  output logic tick_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [1:0]             edge_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      edge_q <= '0;
      tick_o <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], tick_async_i};
      edge_q <= {edge_q[0], sync_q[SYNC_STAGES-1]};
      tick_o <= edge_q[0] & ~edge_q[1];
    end
  end

endmodule

// File: rtl/rtc_time_snapshot.sv
// rtc_time_snapshot: settle, double-sample and present a coherent time snapshot.
// Optional RTC_SNAP_PARITY_EN adds snap_parity_o (even parity of snap_time).
module rtc_time_snapshot
  import rtc_snap_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int SETTLE_CYCLES = 4,
  parameter int MAX_RETRY     = 7
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      tick_async_i,
  input  logic      enable_i,
  input  logic      snap_req_i,
  input  rtc_time_t cur_time_i,
  rtc_time_snapshot_if.master snap_if,
  output logic      tick_o,
  output logic      overrun_o,
  output logic      unstable_o,
`ifdef RTC_SNAP_PARITY_EN
  output logic      snap_parity_o,
`endif
  input  logic      flags_clr_i
);

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [2:0] RTRY_MAX = 3'(MAX_RETRY);

  snap_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [2:0]  retry_q, retry_d;
  logic        pend_q, pend_d;
  rtc_time_t   shadow_q, shadow_d;
  rtc_time_t   snap_q, snap_d;
  logic        ovr_q, ovr_set;
  logic        uns_q, uns_set;
  logic        ev;
  logic        hs;
  logic        same;

  rtc_tick_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .tick_async_i (tick_async_i),
    .tick_o       (tick_o)
  );

  assign ev   = (tick_o | snap_req_i) & enable_i;
  assign hs   = (state_q == S_PRESENT) & snap_if.snap_ready;
  assign same = (cur_time_i == shadow_q);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    retry_d  = retry_q;
    pend_d   = pend_q;
    shadow_d = shadow_q;
    snap_d   = snap_q;
    ovr_set  = 1'b0;
    uns_set  = 1'b0;
    if (!enable_i) begin
      state_d = S_IDLE;
      pend_d  = 1'b0;
      retry_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (ev) begin
            state_d = S_SETTLE;
            cnt_d   = CNT_LOAD;
          end
        end
        S_SETTLE: begin
          if (ev)              cnt_d   = CNT_LOAD;
          else if (cnt_q == 0) state_d = S_SAMPLE;
          else                 cnt_d   = cnt_q - 4'd1;
        end
        S_SAMPLE: begin
          if (ev) begin
            state_d = S_SETTLE;
            cnt_d   = CNT_LOAD;
          end else begin
            shadow_d = cur_time_i;
            state_d  = S_VERIFY;
          end
        end
        S_VERIFY: begin
          if (ev) begin
            state_d = S_SETTLE;
            cnt_d   = CNT_LOAD;
          end else if (same || retry_q == RTRY_MAX) begin
            snap_d  = shadow_q;
            state_d = S_PRESENT;
            retry_d = '0;
            uns_set = ~same;
          end else begin
            retry_d = retry_q + 3'd1;
            cnt_d   = CNT_LOAD;
            state_d = S_SETTLE;
          end
        end
        S_PRESENT: begin
          // A request arriving with the handshake restarts directly.
          if (hs) begin
            pend_d = 1'b0;
            if (pend_q || ev) begin
              state_d = S_SETTLE;
              cnt_d   = CNT_LOAD;
            end else begin
              state_d = S_IDLE;
            end
          end else if (ev) begin
            ovr_set = pend_q;
            pend_d  = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      retry_q  <= '0;
      pend_q   <= 1'b0;
      shadow_q <= '0;
      snap_q   <= '0;
      ovr_q    <= 1'b0;
      uns_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      retry_q  <= retry_d;
      pend_q   <= pend_d;
      shadow_q <= shadow_d;
      snap_q   <= snap_d;
      ovr_q    <= ovr_set | (ovr_q & ~flags_clr_i);
      uns_q    <= uns_set | (uns_q & ~flags_clr_i);
    end
  end

`ifdef RTC_SNAP_PARITY_EN
  logic par_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) par_q <= 1'b0;
    else       par_q <= ^snap_d;
  end

  assign snap_parity_o = par_q;
`endif

  assign snap_if.snap_time  = snap_q;
  assign snap_if.snap_valid = (state_q == S_PRESENT);
  assign overrun_o          = ovr_q;
  assign unstable_o         = uns_q;

endmodule

// File: tb/tb_rtc_time_snapshot.sv
// tb_rtc_time_snapshot: randomized scoreboard bench for rtc_time_snapshot.
// Expected snapshots come from a timeline model of the sampled time.
module tb_rtc_time_snapshot;
  import rtc_snap_pkg::*;

  localparam int SS = 2;
  localparam int SC = 4;
  localparam int MR = 7;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick_async = 1'b0;
  logic        enable = 1'b1;
  logic        snap_req = 1'b0;
  logic        flags_clr = 1'b0;
  logic [43:0] cur_time = '0;
  logic        tick;
  logic        overrun;
  logic        unstable;
`ifdef RTC_SNAP_PARITY_EN
  logic        parity;
`endif

  rtc_time_snapshot_if sif ();

  int   ready_mode = 1;
  logic rnd_ready = 1'b0;
  assign sif.snap_ready = (ready_mode == 2) ? rnd_ready : (ready_mode == 1);

  always #5 clk = ~clk;

  rtc_time_snapshot #(
    .SYNC_STAGES   (SS),
    .SETTLE_CYCLES (SC),
    .MAX_RETRY     (MR)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .tick_async_i  (tick_async),
    .enable_i      (enable),
    .snap_req_i    (snap_req),
    .cur_time_i    (cur_time),
    .snap_if       (sif),
    .tick_o        (tick),
    .overrun_o     (overrun),
    .unstable_o    (unstable),
`ifdef RTC_SNAP_PARITY_EN
    .snap_parity_o (parity),
`endif
    .flags_clr_i   (flags_clr)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Live-time waveform: constant, one step at wstep, or toggling per cycle.
  int          wmode = 0;
  int          wstep = 0;
  logic [43:0] wbase = '0;
  logic [43:0] walt  = '0;

  function automatic logic [43:0] wave(input int c);
    if (wmode == 1) return (c >= wstep) ? walt : wbase;
    if (wmode == 2) return c[0] ? walt : wbase;
    return wbase;
  endfunction

  always @(posedge clk) begin
    #1;
    cur_time  = wave(cyc);
    rnd_ready = ($urandom_range(2) == 0);
  end

  typedef struct {
    int          pres;
    logic [43:0] val;
    logic        unst;
    logic        ovr;
  } exp_t;

  exp_t        q[$];
  logic        unst_m = 1'b0;
  logic        ovr_m  = 1'b0;
  logic [43:0] lastv  = '0;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Sample attempt k reads the live time at s and compares it one cycle later.
  task automatic push_exp(input int e);
    exp_t x;
    int   s;
    for (int k = 0; k <= MR; k++) begin
      s = e + SC + 1 + k * (SC + 2);
      if (wave(s) == wave(s + 1) || k == MR) begin
        if (wave(s) != wave(s + 1)) unst_m = 1'b1;
        x.pres = s + 2;
        x.val  = wave(s);
        x.unst = unst_m;
        x.ovr  = ovr_m;
        lastv  = x.val;
        q.push_back(x);
        break;
      end
    end
  endtask

  int   rise_cnt = 0;
  int   hs_cnt   = 0;
  exp_t cur;
  logic vprev = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      vprev = 1'b0;
    end else begin
      if (sif.snap_valid && !vprev) begin
        rise_cnt++;
        chk("exp_available", 64'(q.size() > 0), 64'd1);
        if (q.size() > 0) begin
          cur = q.pop_front();
          chk("valid_cycle", 64'(cyc), 64'(cur.pres));
          chk("snap_time", 64'(sif.snap_time), 64'(cur.val));
          chk("unstable", 64'(unstable), 64'(cur.unst));
          chk("overrun", 64'(overrun), 64'(cur.ovr));
`ifdef RTC_SNAP_PARITY_EN
          chk("parity", 64'(parity), 64'(^cur.val));
`endif
        end
      end
      if (sif.snap_valid && sif.snap_ready) begin
        chk("hs_time", 64'(sif.snap_time), 64'(cur.val));
        hs_cnt++;
      end
      vprev = sif.snap_valid;
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_hs(input int target, input string nm);
    int t = 0;
    while (hs_cnt < target && t < 400) begin
      step();
      t++;
    end
    chk(nm, 64'(hs_cnt >= target), 64'd1);
  endtask

  task automatic wait_rise(input int target, input string nm);
    int t = 0;
    while (rise_cnt < target && t < 400) begin
      step();
      t++;
    end
    chk(nm, 64'(rise_cnt >= target), 64'd1);
  endtask

  // Raised in cycle c, first sampled at edge c+1, pulse expected in cycle c+SS+2.
  task automatic do_tick(input bit with_req, input bit with_rdy);
    int e;
    tick_async = 1'b1;
    e = cyc + SS + 2;
    while (cyc < e - 1) step();
    chk("tick_early", 64'(tick), 64'd0);
    step();
    chk("tick_pulse", 64'(tick), 64'd1);
    if (with_req) snap_req = 1'b1;
    if (with_rdy) ready_mode = 1;
    step();
    snap_req = 1'b0;
    if (with_rdy) ready_mode = 0;
    chk("tick_width", 64'(tick), 64'd0);
    tick_async = 1'b0;
  endtask

  task automatic do_req();
    snap_req = 1'b1;
    step();
    snap_req = 1'b0;
  endtask

  task automatic clr_flags();
    flags_clr = 1'b1;
    step();
    flags_clr = 1'b0;
    unst_m = 1'b0;
    ovr_m  = 1'b0;
    chk("clr_unstable", 64'(unstable), 64'd0);
    chk("clr_overrun", 64'(overrun), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int          tgt;
    int          e;
    int          kind;
    int          r;
    logic [63:0] r64;
    logic [43:0] held;

    step(3);
    chk("rst_valid", 64'(sif.snap_valid), 64'd0);
    chk("rst_time", 64'(sif.snap_time), 64'd0);
    chk("rst_tick", 64'(tick), 64'd0);
    chk("rst_overrun", 64'(overrun), 64'd0);
    chk("rst_unstable", 64'(unstable), 64'd0);
    rst = 1'b0;
    step(3);

    // 2024, 12:34:56 held constant; tick-driven snapshot.
    wbase = {12'd2024, 4'd5, 5'd17, 3'd2, 2'd0, 6'd12, 6'd34, 6'd56};
    wmode = 0;
    tgt = hs_cnt + 1;
    push_exp(cyc + SS + 2);
    do_tick(1'b0, 1'b0);
    wait_hs(tgt, "hs_const");
    step(3);

    // Seconds roll 56->57 exactly in the first verify cycle: one retry.
    e = cyc;
    wmode = 1;
    walt  = wbase + 44'd1;
    wstep = e + SC + 2;
    tgt = hs_cnt + 1;
    push_exp(e);
    do_req();
    wait_hs(tgt, "hs_retry");
    chk("retry_sec", 64'(sif.snap_time[5:0]), 64'd57);
    chk("retry_stable", 64'(unstable), 64'd0);
    step(3);

    // Time toggling every cycle forces a present with unstable set.
    e = cyc;
    wmode = 2;
    walt  = wbase ^ 44'h1;
    tgt = hs_cnt + 1;
    push_exp(e);
    do_req();
    wait_hs(tgt, "hs_forced");
    chk("forced_unstable", 64'(unstable), 64'd1);
    wmode = 0;
    clr_flags();
    step(3);

    // Two ticks while unconsumed: pending, then overrun.
    ready_mode = 0;
    tgt = rise_cnt + 1;
    push_exp(cyc);
    do_req();
    wait_rise(tgt, "rise_pend");
    do_tick(1'b0, 1'b0);
    step(4);
    chk("pend_no_overrun", 64'(overrun), 64'd0);
    do_tick(1'b0, 1'b0);
    chk("overrun_set", 64'(overrun), 64'd1);
    ovr_m = 1'b1;
    step(3);
    tgt = rise_cnt + 1;
    push_exp(cyc);
    ready_mode = 1;
    step();
    ready_mode = 0;
    wait_rise(tgt, "rise_after_pend");
    tgt = hs_cnt + 1;
    ready_mode = 1;
    wait_hs(tgt, "hs_after_pend");
    clr_flags();
    step(3);

    // Tick in the same cycle as the handshake restarts without overrun.
    ready_mode = 0;
    tgt = rise_cnt + 1;
    push_exp(cyc);
    do_req();
    wait_rise(tgt, "rise_tick_rdy");
    step(2);
    tgt = rise_cnt + 1;
    push_exp(cyc + SS + 2);
    do_tick(1'b0, 1'b1);
    wait_rise(tgt, "rise_tick_rdy2");
    chk("tick_rdy_overrun", 64'(overrun), 64'd0);
    tgt = hs_cnt + 1;
    ready_mode = 1;
    wait_hs(tgt, "hs_tick_rdy2");
    step(3);

    // Tick and request together: exactly one snapshot.
    tgt = hs_cnt + 1;
    push_exp(cyc + SS + 2);
    do_tick(1'b1, 1'b0);
    wait_hs(tgt, "hs_tick_req");
    step(20);
    chk("single_snapshot", 64'(q.size()), 64'd0);
    chk("no_extra_valid", 64'(sif.snap_valid), 64'd0);

    // Second request while settling restarts the wait.
    e = cyc;
    do_req();
    step();
    tgt = hs_cnt + 1;
    push_exp(e + 2);
    do_req();
    wait_hs(tgt, "hs_restart");
    step(3);

    // Enable dropped mid-settle: abort, time retained.
    held = lastv;
    do_req();
    step();
    enable = 1'b0;
    step();
    chk("dis_valid", 64'(sif.snap_valid), 64'd0);
    enable = 1'b1;
    step(20);
    chk("dis_no_valid", 64'(sif.snap_valid), 64'd0);
    chk("dis_time_kept", 64'(sif.snap_time), 64'(held));

    // Reset while presenting clears everything next cycle.
    ready_mode = 0;
    tgt = rise_cnt + 1;
    push_exp(cyc);
    do_req();
    wait_rise(tgt, "rise_rst");
    rst = 1'b1;
    step();
    chk("mid_rst_valid", 64'(sif.snap_valid), 64'd0);
    chk("mid_rst_time", 64'(sif.snap_time), 64'd0);
    chk("mid_rst_overrun", 64'(overrun), 64'd0);
    chk("mid_rst_unstable", 64'(unstable), 64'd0);
    rst = 1'b0;
    unst_m = 1'b0;
    ovr_m  = 1'b0;
    step(4);

    // Randomized transactions with random consumer back-pressure.
    ready_mode = 2;
    for (int i = 0; i < 24; i++) begin
      kind = $urandom_range(2);
      r    = $urandom_range(9);
      wmode = (r < 6) ? 0 : (r < 9) ? 1 : 2;
      r64   = {$urandom, $urandom};
      wbase = r64[43:0];
      walt  = wbase ^ (44'h1 << $urandom_range(43));
      e = (kind == 0) ? cyc : cyc + SS + 2;
      wstep = e + SC + 1 + $urandom_range(2 * (SC + 2));
      tgt = hs_cnt + 1;
      push_exp(e);
      if (kind == 0) do_req();
      else           do_tick(kind == 2, 1'b0);
      wait_hs(tgt, "hs_random");
      if ($urandom_range(2) == 0) clr_flags();
      step($urandom_range(6, 2));
    end

    step(10);
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
